// File: rtl/fwrisc_exec_protocol_checker.sv
`default_nettype none
// ============================================================================
// fwrisc_exec_protocol_checker: passive decode->exec->regfile protocol monitor
// Revision: 1.0
// ============================================================================
module fwrisc_exec_protocol_checker #(
  parameter int XLEN        = 32,
  parameter int MAX_LATENCY = 40,
  parameter int LAT_W       = 8,
  parameter int CNT_W       = 16,
  parameter int CHECK_PC    = 1,
  parameter int ASSERT_EN   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             decode_valid,
  input  logic             instr_complete,
  input  logic             instr_c,
  input  logic [4:0]       op_type,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [5:0]       op,
  input  logic [XLEN-1:0]  op_c,
  input  logic [5:0]       rd,
  input  logic [5:0]       rd_waddr,
  input  logic [XLEN-1:0]  rd_wdata,
  input  logic             rd_wen,
  input  logic [XLEN-1:0]  pc,
  input  logic             pc_seq,
  output logic [5:0]       err,
  output logic             any_err,
  output logic [CNT_W-1:0] retired,
  output logic [LAT_W-1:0] max_lat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        err_q, err_d, err_set;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [LAT_W-1:0]  max_lat_q, max_lat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              cap_c_q, cap_c_d;
  logic [4:0]        cap_op_type_q, cap_op_type_d;
  logic [XLEN-1:0]   cap_op_a_q, cap_op_a_d;
  logic [XLEN-1:0]   cap_op_b_q, cap_op_b_d;
  logic [5:0]        cap_op_q, cap_op_d;
  logic [XLEN-1:0]   cap_op_c_q, cap_op_c_d;
  logic [5:0]        cap_rd_q, cap_rd_d;
  logic [XLEN-1:0]   cap_pc_q, cap_pc_d;
  logic [XLEN-1:0]   pc_exp_q, pc_exp_d;
  logic              pc_exp_vld_q, pc_exp_vld_d;

  logic              w_fields_differ;
  logic [XLEN-1:0]   w_pc_step;
  logic              w_unused_wdata;

  // Write data is outside the protocol being checked.
  assign w_unused_wdata = ^rd_wdata;

  assign w_fields_differ = (cap_c_q != instr_c) || (cap_op_type_q != op_type) ||
                           (cap_op_a_q != op_a) || (cap_op_b_q != op_b) ||
                           (cap_op_q != op) || (cap_op_c_q != op_c) ||
                           (cap_rd_q != rd) || (cap_pc_q != pc);
  assign w_pc_step = {{(XLEN-3){1'b0}}, (cap_c_q ? 3'd2 : 3'd4)};

  always_comb begin
    state_d       = state_q;
    err_set       = '0;
    retired_d     = retired_q;
    max_lat_d     = max_lat_q;
    lat_d         = lat_q;
    cap_c_d       = cap_c_q;
    cap_op_type_d = cap_op_type_q;
    cap_op_a_d    = cap_op_a_q;
    cap_op_b_d    = cap_op_b_q;
    cap_op_d      = cap_op_q;
    cap_op_c_d    = cap_op_c_q;
    cap_rd_d      = cap_rd_q;
    cap_pc_d      = cap_pc_q;
    pc_exp_d      = pc_exp_q;
    pc_exp_vld_d  = pc_exp_vld_q;

    case (state_q)
      S_IDLE: begin
        if (instr_complete) err_set[0] = 1'b1;
        if (decode_valid) begin
          cap_c_d       = instr_c;
          cap_op_type_d = op_type;
          cap_op_a_d    = op_a;
          cap_op_b_d    = op_b;
          cap_op_d      = op;
          cap_op_c_d    = op_c;
          cap_rd_d      = rd;
          cap_pc_d      = pc;
          lat_d         = {{(LAT_W-1){1'b0}}, 1'b1};
          state_d       = S_BUSY;
          if ((CHECK_PC != 0) && pc_exp_vld_q && (pc != pc_exp_q)) err_set[5] = 1'b1;
          pc_exp_vld_d  = 1'b0;
        end
      end
      S_BUSY: begin
        if (!decode_valid || w_fields_differ) err_set[1] = 1'b1;
        lat_d = lat_q + 1'b1;
        // A complete on the limit cycle takes priority over the timeout.
        if (instr_complete) begin
          if (rd_wen && (rd_waddr != cap_rd_q)) err_set[2] = 1'b1;
          if (lat_q > max_lat_q) max_lat_d = lat_q;
          if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + 1'b1;
          pc_exp_vld_d = pc_seq;
          if (pc_seq) pc_exp_d = cap_pc_q + w_pc_step;
          state_d = S_DONE;
        end else if (lat_q == LAT_W'(MAX_LATENCY)) begin
          err_set[4]   = 1'b1;
          pc_exp_vld_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_DONE: begin
        if (instr_complete) err_set[0] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_wen && !((state_q == S_BUSY) && instr_complete)) err_set[3] = 1'b1;
    err_d = err_q | err_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      err_q         <= '0;
      retired_q     <= '0;
      max_lat_q     <= '0;
      lat_q         <= '0;
      cap_c_q       <= 1'b0;
      cap_op_type_q <= '0;
      cap_op_a_q    <= '0;
      cap_op_b_q    <= '0;
      cap_op_q      <= '0;
      cap_op_c_q    <= '0;
      cap_rd_q      <= '0;
      cap_pc_q      <= '0;
      pc_exp_q      <= '0;
      pc_exp_vld_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_q         <= err_d;
      retired_q     <= retired_d;
      max_lat_q     <= max_lat_d;
      lat_q         <= lat_d;
      cap_c_q       <= cap_c_d;
      cap_op_type_q <= cap_op_type_d;
      cap_op_a_q    <= cap_op_a_d;
      cap_op_b_q    <= cap_op_b_d;
      cap_op_q      <= cap_op_d;
      cap_op_c_q    <= cap_op_c_d;
      cap_rd_q      <= cap_rd_d;
      cap_pc_q      <= cap_pc_d;
      pc_exp_q      <= pc_exp_d;
      pc_exp_vld_q  <= pc_exp_vld_d;
    end
  end

  assign err     = err_q;
  assign any_err = |err_q;
  assign retired = retired_q;
  assign max_lat = max_lat_q;

  generate
    if (ASSERT_EN != 0) begin : g_assert
`ifdef FORMAL
      for (genvar i = 0; i < 6; i++) begin : g_err_bit
        always_ff @(posedge clock) begin
          if (!reset) assert (!err_set[i]);
        end
      end
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_exec_protocol_checker.sv
`default_nettype none
// ============================================================================
// tb_fwrisc_exec_protocol_checker: directed scoreboard bench for the checker
// Revision: 1.0
// ============================================================================
module tb_fwrisc_exec_protocol_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        decode_valid, instr_complete, instr_c, rd_wen, pc_seq;
  logic [4:0]  op_type;
  logic [31:0] op_a, op_b, op_c, rd_wdata, pc;
  logic [5:0]  op, rd, rd_waddr;
  logic [5:0]  err;
  logic        any_err;
  logic [3:0]  retired;
  logic [7:0]  max_lat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [5:0] err;
    logic [3:0] ret;
    logic [7:0] lat;
  } exp_t;
  exp_t sb[$];

  fwrisc_exec_protocol_checker #(
    .XLEN(32), .MAX_LATENCY(8), .LAT_W(8), .CNT_W(4), .CHECK_PC(1), .ASSERT_EN(0)
  ) dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid),
    .instr_complete(instr_complete), .instr_c(instr_c), .op_type(op_type),
    .op_a(op_a), .op_b(op_b), .op(op), .op_c(op_c), .rd(rd),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen), .pc(pc),
    .pc_seq(pc_seq), .err(err), .any_err(any_err), .retired(retired),
    .max_lat(max_lat)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    decode_valid = 0; instr_complete = 0; instr_c = 0; rd_wen = 0; pc_seq = 0;
    op_type = 0; op_a = 0; op_b = 0; op_c = 0; rd_wdata = 0; pc = 0;
    op = 0; rd = 0; rd_waddr = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] e,
                            input logic [3:0] r, input logic [7:0] m);
    exp_t x;
    x.tag = tag; x.err = e; x.ret = r; x.lat = m;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      checks++;
      assert (err === x.err) else begin
        errors++;
        $error("FAIL %s err: observed %b expected %b", x.tag, err, x.err);
      end
      checks++;
      assert (any_err === (|x.err)) else begin
        errors++;
        $error("FAIL %s any_err: observed %b expected %b", x.tag, any_err, |x.err);
      end
      checks++;
      assert (retired === x.ret) else begin
        errors++;
        $error("FAIL %s retired: observed %0d expected %0d", x.tag, retired, x.ret);
      end
      checks++;
      assert (max_lat === x.lat) else begin
        errors++;
        $error("FAIL %s max_lat: observed %0d expected %0d", x.tag, max_lat, x.lat);
      end
    end
  endtask

  // Present an instruction in IDLE; decode_valid and fields stay held through BUSY.
  task automatic issue(input logic [31:0] pc_v, input logic c_v, input logic [5:0] rd_v);
    decode_valid = 1; instr_c = c_v; pc = pc_v; rd = rd_v;
    op_type = pc_v[4:0]; op_a = pc_v ^ 32'hA5A5_0000; op_b = ~pc_v;
    op = pc_v[7:2]; op_c = pc_v + 32'd17;
    cyc();
  endtask

  // Complete cycle, then the single DONE cycle with all strobes low.
  task automatic finish_instr(input logic [5:0] waddr, input logic wen, input logic seq);
    instr_complete = 1; rd_wen = wen; rd_waddr = waddr; pc_seq = seq;
    rd_wdata = 32'hDEAD_BEEF;
    cyc();
    instr_complete = 0; rd_wen = 0; pc_seq = 0; decode_valid = 0;
    cyc();
  endtask

  task automatic run_instr(input logic [31:0] pc_v, input logic c_v, input logic [5:0] rd_v,
                           input int lat, input logic seq);
    issue(pc_v, c_v, rd_v);
    repeat (lat - 1) cyc();
    finish_instr(rd_v, 1'b1, seq);
  endtask

  initial begin
    reset = 1;
    clear_inputs();

    // Reset state
    expect_out("reset", 6'b000000, 4'd0, 8'd0);
    do_reset();
    check_out();

    // Sequential PC, 32-bit instruction, latency 3 then 2
    expect_out("seq4_first", 6'b000000, 4'd1, 8'd3);
    run_instr(32'h100, 1'b0, 6'd5, 3, 1'b1);
    check_out();
    expect_out("seq4_second", 6'b000000, 4'd2, 8'd3);
    run_instr(32'h104, 1'b0, 6'd5, 2, 1'b1);
    check_out();

    // Compressed instruction: next PC must be +2
    do_reset();
    run_instr(32'h100, 1'b1, 6'd5, 3, 1'b1);
    expect_out("seq2_bad_pc", 6'b100000, 4'd2, 8'd3);
    run_instr(32'h104, 1'b0, 6'd5, 3, 1'b1);
    check_out();
    do_reset();
    run_instr(32'h100, 1'b1, 6'd5, 3, 1'b1);
    expect_out("seq2_good_pc", 6'b000000, 4'd2, 8'd3);
    run_instr(32'h102, 1'b0, 6'd5, 3, 1'b1);
    check_out();

    // Operand change mid-BUSY and wrong writeback address
    do_reset();
    expect_out("unstable_rd_mismatch", 6'b000110, 4'd1, 8'd3);
    issue(32'h300, 1'b0, 6'd5);
    op_a = op_a ^ 32'h1;
    cyc();
    op_a = op_a ^ 32'h1;
    cyc();
    finish_instr(6'd6, 1'b1, 1'b1);
    check_out();

    // Spurious complete in IDLE, stray rd_wen in BUSY
    do_reset();
    expect_out("idle_complete", 6'b000001, 4'd0, 8'd0);
    instr_complete = 1;
    cyc();
    instr_complete = 0;
    check_out();
    expect_out("stray_wen", 6'b001001, 4'd1, 8'd2);
    issue(32'h200, 1'b0, 6'd3);
    rd_wen = 1; rd_waddr = 6'd3;
    cyc();
    rd_wen = 0;
    finish_instr(6'd3, 1'b1, 1'b0);
    check_out();

    // Complete exactly on the latency limit wins over timeout
    do_reset();
    expect_out("complete_at_limit", 6'b000000, 4'd1, 8'd8);
    run_instr(32'h400, 1'b0, 6'd7, 8, 1'b0);
    check_out();

    // Timeout: no error one cycle before the limit, err[4] on it
    do_reset();
    expect_out("pre_timeout", 6'b000000, 4'd0, 8'd0);
    issue(32'h500, 1'b0, 6'd1);
    repeat (7) cyc();
    check_out();
    expect_out("timeout", 6'b010000, 4'd0, 8'd0);
    cyc();
    check_out();
    decode_valid = 0;
    cyc();

    // Reset mid-instruction abandons it silently
    issue(32'h600, 1'b0, 6'd2);
    repeat (2) cyc();
    expect_out("reset_mid_busy", 6'b000000, 4'd0, 8'd0);
    reset = 1; decode_valid = 0;
    cyc();
    reset = 0;
    check_out();
    expect_out("after_reset_instr", 6'b000000, 4'd1, 8'd2);
    run_instr(32'h700, 1'b0, 6'd2, 2, 1'b1);
    check_out();

    // Retire counter saturation and PC wrap at 2^32
    do_reset();
    expect_out("retired_15", 6'b000000, 4'd15, 8'd2);
    for (int k = 0; k < 15; k++) run_instr(32'hFFFF_FFB8 + 32'(4 * k), 1'b0, 6'(k), 2, 1'b1);
    check_out();
    expect_out("retired_sat", 6'b000000, 4'd15, 8'd2);
    for (int k = 15; k < 18; k++) run_instr(32'hFFFF_FFB8 + 32'(4 * k), 1'b0, 6'(k), 2, 1'b1);
    check_out();
    expect_out("pc_wrap", 6'b000000, 4'd15, 8'd2);
    run_instr(32'h0, 1'b0, 6'd1, 2, 1'b1);
    check_out();

    // Complete strobe during the DONE cycle
    do_reset();
    expect_out("done_complete", 6'b000001, 4'd1, 8'd2);
    issue(32'h800, 1'b0, 6'd4);
    cyc();
    instr_complete = 1; rd_wen = 1; rd_waddr = 6'd4;
    cyc();
    rd_wen = 0;
    cyc();
    instr_complete = 0; decode_valid = 0;
    check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fwrisc_exec_protocol_checker.md
Name: fwrisc_exec_protocol_checker

Overview:
- Parametrised successor to the exec formal smoke checker.
- Passively monitors the decode→exec→regfile interface of fwrisc_exec.
- Tracks each issued instruction through a small FSM and checks handshake, stability, writeback address, completion latency and next-PC sequencing.
- Reports sticky error bits, a retire count and the worst-case latency.
- Instantiated as the CHECKER_MODULE in exec formal and simulation benches.

Parameters:
- XLEN, 32: width of op_a/op_b/op_c/pc/rd_wdata.
- MAX_LATENCY, 40: cycles allowed from issue to instr_complete; must be ≥2.
- LAT_W, 8: width of latency counter; requires 2^LAT_W > MAX_LATENCY.
- CNT_W, 16: width of retire counter.
- CHECK_PC, 1: enable next-PC check.
- ASSERT_EN, 0: when 1 and FORMAL defined, each error condition is also an assert.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- decode_valid  in  1  instruction presented to exec
- instr_complete  in  1  exec retire strobe
- instr_c  in  1  compressed instruction
- op_type  in  5  operation class
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B
- op  in  6  operation code
- op_c  in  XLEN  operand C / immediate
- rd  in  6  destination register
- rd_waddr  in  6  regfile write address
- rd_wdata  in  XLEN  regfile write data
- rd_wen  in  1  regfile write enable
- pc  in  XLEN  current PC
- pc_seq  in  1  exec signals sequential next PC
- err  out  6  sticky errors: [0] spurious complete, [1] input instability, [2] rd mismatch, [3] stray rd_wen, [4] timeout, [5] pc sequence
- any_err  out  1  OR of err
- retired  out  CNT_W  completed instruction count, saturating
- max_lat  out  LAT_W  largest observed issue-to-complete latency

Behaviour:
- Reset (synchronous, active-high): state=IDLE; err=0; retired=0; max_lat=0; lat_cnt=0; capture regs=0; pc_exp_vld=0. Reset mid-instruction abandons it with no error.
- FSM states: IDLE, BUSY, DONE.
- IDLE, decode_valid=1:
  - Capture instr_c, op_type, op_a, op_b, op, op_c, rd, pc; lat_cnt=1; go to BUSY.
  - If CHECK_PC and pc_exp_vld and pc≠pc_exp, set err[5]; clear pc_exp_vld.
- IDLE, instr_complete=1: set err[0].
- BUSY, each cycle:
  - If decode_valid=0, or any captured field differs from the live input, set err[1] once per instruction.
  - lat_cnt increments.
- BUSY, instr_complete=1:
  - If rd_wen=1 and rd_waddr≠captured rd, set err[2].
  - max_lat = max(max_lat, lat_cnt).
  - retired increments, saturating at all-ones.
  - If pc_seq=1: pc_exp = cap_pc + (cap_instr_c ? 2 : 4), modulo 2^XLEN; pc_exp_vld=1. Otherwise pc_exp_vld=0 (branch/jump, target not checked).
  - Go to DONE.
- BUSY, lat_cnt==MAX_LATENCY with no complete: set err[4]; go to IDLE; pc_exp_vld=0.
- DONE: lasts exactly one cycle.
  - decode_valid ignored; instr_complete=1 sets err[0].
  - Go to IDLE.
  - Back-to-back issue interval is therefore ≥2 cycles after complete.
- rd_wen=1 in any cycle other than a BUSY instr_complete cycle sets err[3].
- Errors are sticky until reset; any_err is combinational OR of err.
- Outputs are registered except any_err.
- Complete in the issue cycle itself is not possible; the IDLE capture cycle is not BUSY.
- Simultaneous timeout and complete at lat_cnt==MAX_LATENCY: complete wins, no err[4].

Test Plan:
- Issue at pc=0x100, instr_c=0; complete after 3 cycles with rd_wen=1, rd_waddr=rd=5, pc_seq=1; next issue pc=0x104 → err=0, retired=1, max_lat=3.
- Same sequence with instr_c=1 and next pc=0x104 (expected 0x102) → err[5]=1; with pc=0x102 → err=0.
- Change op_a mid-BUSY, then complete with rd_waddr=6 while rd=5 → err[1]=1, err[2]=1.
- Pulse instr_complete in IDLE; pulse rd_wen in BUSY before complete → err[0]=1, err[3]=1, any_err=1.
- MAX_LATENCY=8, hold decode_valid with no complete → err[4] set on cycle 8; retired=0; reset mid-BUSY then a normal instruction → err=0, retired=1.
- Issue 2^CNT_W+2 instructions with CNT_W=4 → retired saturates at 15; pc=0xFFFFFFFC with pc_seq=1 → expected next pc 0x0 accepted.
